// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready write port into a FIFO, LSB-first framing on tx.
// Define UART_TX_CTS_EN to add the cts_n flow-control input (frames start only while cts_n is low).
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_LEN   = 8,
    parameter int PARITY_BIT = 0,
    parameter int STOP_BIT   = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_LEN-1:0]           in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef UART_TX_CTS_EN
    ,
    input  logic                          cts_n
`endif
);

    localparam int HALF_DIV = CLK_FREQ / (2 * BAUD_RATE);
    localparam int DW       = $clog2(HALF_DIV);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(HALF_DIV - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_LEN - 1);
    // Stop length in half-bits minus one: 2, 4 or 3 half-bits.
    localparam logic [1:0]    STOP_LAST = (STOP_BIT == 2) ? 2'd3 :
                                          (STOP_BIT == 3) ? 2'd2 : 2'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    // ---------------- FIFO ----------------
    logic [DATA_LEN-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q, count_d;
    logic [DATA_LEN-1:0] head;
    logic                wr_en, pop;

    assign in_ready = (count_q != FULL_CNT);
    assign wr_en    = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q];
    assign count_d  = count_q + CW'(wr_en) - CW'(pop);

    // NOTE: the storage array has no reset; count_q == 0 already marks every entry as invalid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_data;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // ---------------- flow control ----------------
    logic cts_ok;
`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cts_sync_q <= 2'b11;
        else      cts_sync_q <= {cts_sync_q[0], cts_n};
    end

    assign cts_ok = ~cts_sync_q[1];
`else
    assign cts_ok = 1'b1;
`endif

    // ---------------- framing FSM ----------------
    state_e              state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic [1:0]          half_q, half_d;
    logic [3:0]          bit_q, bit_d;
    logic [DATA_LEN-1:0] shift_q, shift_d;
    logic                parity_q, parity_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                half_tick, bit_end, start, can_start;

    assign can_start = (count_q != '0) && cts_ok;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        half_d    = half_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        start     = 1'b0;
        half_tick = (div_q == DIV_LAST);
        bit_end   = half_tick && (half_q == ((state_q == S_STOP) ? STOP_LAST : 2'd1));

        if (state_q != S_IDLE) begin
            div_d = half_tick ? '0 : div_q + DW'(1);
            if (bit_end)        half_d = '0;
            else if (half_tick) half_d = half_q + 2'd1;
        end

        case (state_q)
            S_IDLE:   start = can_start;
            S_START:  if (bit_end) begin
                          state_d = S_DATA;
                          bit_d   = '0;
                      end
            S_DATA:   if (bit_end) begin
                          shift_d = shift_q >> 1;
                          if (bit_q == DATA_LAST) state_d = (PARITY_BIT != 0) ? S_PARITY : S_STOP;
                          else                    bit_d   = bit_q + 4'd1;
                      end
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP:   if (bit_end) begin
                          state_d = S_IDLE;
                          start   = can_start;
                      end
            default:  state_d = S_IDLE;
        endcase

        // Frame start restarts the divider so bit edges line up with the start bit.
        if (start) begin
            state_d  = S_START;
            div_d    = '0;
            half_d   = '0;
            shift_d  = head;
            parity_d = (PARITY_BIT == 1) ? ~^head : ^head;
        end
        pop = start;

        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
            S_PARITY: tx_d = parity_q;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_q != S_IDLE) || (count_q != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            half_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            half_q   <= half_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: five instances at 10 clk/bit covering 8N1, odd/even parity,
// 1.5 and 2 stop bits; instance 0 also exercises FIFO fill, mid-frame reset and (if enabled) CTS.
module tb_uart_tx_fifo;

    localparam int N = 5;
    localparam int PAR_CFG  [N] = '{0, 1, 2, 0, 0};
    localparam int STOP_CFG [N] = '{1, 1, 1, 3, 2};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic [N-1:0] in_valid = '0;
`ifdef UART_TX_CTS_EN
    logic         cts_n = 1'b0;
`endif

    wire  [N-1:0] in_ready;
    wire  [N-1:0] tx_w;
    wire  [N-1:0] busy_w;
    wire  [4:0]   cnt_w [N];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        uart_tx_fifo #(
            .CLK_FREQ  (1_000_000),
            .BAUD_RATE (100_000),
            .DATA_LEN  (8),
            .PARITY_BIT(PAR_CFG[g]),
            .STOP_BIT  (STOP_CFG[g]),
            .FIFO_DEPTH(16)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_data   (in_data),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .tx        (tx_w[g]),
            .busy      (busy_w[g]),
            .fifo_count(cnt_w[g])
`ifdef UART_TX_CTS_EN
            ,
            .cts_n     (g == 0 ? cts_n : 1'b0)
`endif
        );
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // Drive one word at a negedge; returns at the negedge just after the accepting edge.
    task automatic send(input int g, input logic [7:0] d);
        in_data     = d;
        in_valid[g] = 1'b1;
        @(negedge clk);
        in_valid[g] = 1'b0;
    endtask

    // Called at the negedge showing the first start-bit cycle; checks every cycle of each slot.
    task automatic check_frame(input int g, input logic [7:0] d, input string name);
        int par      = PAR_CFG[g];
        int stop_cyc = (STOP_CFG[g] == 2) ? 20 : (STOP_CFG[g] == 3) ? 15 : 10;
        int nslot    = (par != 0) ? 11 : 10;
        for (int s = 0; s < nslot; s++) begin
            logic exp_b;
            logic got_b;
            logic bad;
            int   len;
            len = 10;
            bad = 1'b0;
            if (s == 0)                    exp_b = 1'b0;
            else if (s <= 8)               exp_b = d[s-1];
            else if (par != 0 && s == 9)   exp_b = (par == 1) ? ~^d : ^d;
            else begin
                exp_b = 1'b1;
                len   = stop_cyc;
            end
            got_b = exp_b;
            for (int c = 0; c < len; c++) begin
                if (tx_w[g] !== exp_b) begin
                    bad   = 1'b1;
                    got_b = tx_w[g];
                end
                @(negedge clk);
            end
            n_checks++;
            if (bad) begin
                n_fail++;
                $display("FAIL %s slot %0d: tx got %b expected %b", name, s, got_b, exp_b);
            end
        end
    endtask

    task automatic wait_tx_low(input int g, input int maxc, input string name);
        int waited = 0;
        while (tx_w[g] !== 1'b0 && waited < maxc) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (tx_w[g] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: start bit not seen, got tx=%b after %0d clk expected 0 within %0d",
                     name, tx_w[g], waited, maxc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (tx_w !== 5'b11111) begin
            n_fail++; $display("FAIL reset_tx: got %b expected 11111", tx_w);
        end
        n_checks++;
        if (in_ready !== 5'b11111) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 11111", in_ready);
        end
        n_checks++;
        if (busy_w !== 5'b00000) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 00000", busy_w);
        end
        for (int g = 0; g < N; g++) begin
            n_checks++;
            if (cnt_w[g] !== 5'd0) begin
                n_fail++; $display("FAIL reset_count[%0d]: got %0d expected 0", g, cnt_w[g]);
            end
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_8n1();
        send(0, 8'hA5);
        n_checks++;
        if (tx_w[0] !== 1'b1 || cnt_w[0] !== 5'd1) begin
            n_fail++; $display("FAIL 8n1_accept: got tx=%b count=%0d expected tx=1 count=1", tx_w[0], cnt_w[0]);
        end
        @(negedge clk);
        n_checks++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b1 || cnt_w[0] !== 5'd0) begin
            n_fail++;
            $display("FAIL 8n1_pop: got tx=%b busy=%b count=%0d expected tx=1 busy=1 count=0",
                     tx_w[0], busy_w[0], cnt_w[0]);
        end
        @(negedge clk);
        check_frame(0, 8'hA5, "8n1_a5");
        n_checks++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
            n_fail++; $display("FAIL 8n1_end: got tx=%b busy=%b expected tx=1 busy=0", tx_w[0], busy_w[0]);
        end
    endtask

    task automatic test_parity();
        for (int g = 1; g <= 2; g++) begin
            send(g, 8'h07);
            @(negedge clk);
            @(negedge clk);
            check_frame(g, 8'h07, (g == 1) ? "parity_odd" : "parity_even");
            n_checks++;
            if (busy_w[g] !== 1'b0) begin
                n_fail++; $display("FAIL parity_end[%0d]: busy got %b expected 0", g, busy_w[g]);
            end
        end
    endtask

    task automatic test_stop_bits();
        in_data     = 8'h96;
        in_valid[3] = 1'b1;
        @(negedge clk);
        in_data     = 8'h4B;
        @(negedge clk);
        in_valid[3] = 1'b0;
        @(negedge clk);
        check_frame(3, 8'h96, "stop15_first");
        check_frame(3, 8'h4B, "stop15_second");
        n_checks++;
        if (busy_w[3] !== 1'b0 || tx_w[3] !== 1'b1) begin
            n_fail++; $display("FAIL stop15_end: got busy=%b tx=%b expected busy=0 tx=1", busy_w[3], tx_w[3]);
        end
        send(4, 8'hE1);
        @(negedge clk);
        @(negedge clk);
        check_frame(4, 8'hE1, "stop20");
        n_checks++;
        if (busy_w[4] !== 1'b0) begin
            n_fail++; $display("FAIL stop20_end: busy got %b expected 0", busy_w[4]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [20];
        int   acc        = 0;
        int   peak       = 0;
        int   first_full = -1;
        logic rerise_seen = 1'b0;
        logic rerise_ok   = 1'b0;
        for (int i = 0; i < 20; i++) words[i] = 8'(i * 29 + 17);
        fork
            begin
                int guard = 0;
                in_valid[0] = 1'b1;
                while (acc < 20 && guard < 5000) begin
                    if (int'(cnt_w[0]) > peak) peak = int'(cnt_w[0]);
                    if (first_full >= 0 && !rerise_seen && cnt_w[0] == 5'd15) begin
                        rerise_seen = 1'b1;
                        rerise_ok   = in_ready[0];
                    end
                    if (in_ready[0]) begin
                        in_data = words[acc];
                        acc++;
                    end else if (first_full < 0) begin
                        first_full = acc;
                    end
                    @(negedge clk);
                    guard++;
                end
                in_valid[0] = 1'b0;
            end
            begin
                wait_tx_low(0, 10, "b2b_first_start");
                for (int i = 0; i < 20; i++) check_frame(0, words[i], "b2b_frame");
            end
        join
        n_checks++;
        if (first_full != 17) begin
            n_fail++; $display("FAIL b2b_accepted_before_full: got %0d expected 17", first_full);
        end
        n_checks++;
        if (peak != 16) begin
            n_fail++; $display("FAIL b2b_peak_count: got %0d expected 16", peak);
        end
        n_checks++;
        if (!(rerise_seen && rerise_ok)) begin
            n_fail++; $display("FAIL b2b_in_ready_rerise: got seen=%b ready=%b expected 1 1", rerise_seen, rerise_ok);
        end
        n_checks++;
        if (busy_w[0] !== 1'b0 || acc != 20) begin
            n_fail++; $display("FAIL b2b_end: got busy=%b accepted=%0d expected busy=0 accepted=20", busy_w[0], acc);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic stray;
        in_valid[0] = 1'b1;
        in_data     = 8'h11;
        @(negedge clk);
        in_data     = 8'h22;
        @(negedge clk);
        in_data     = 8'h33;
        @(negedge clk);
        in_valid[0] = 1'b0;
        // Now 2 clk after the first accept; frame 2 data bit 2 (value 0) is on the line 138 clk later.
        repeat (138) @(negedge clk);
        n_checks++;
        if (tx_w[0] !== 1'b0 || cnt_w[0] !== 5'd1 || busy_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_before_reset: got tx=%b count=%0d busy=%b expected tx=0 count=1 busy=1",
                     tx_w[0], cnt_w[0], busy_w[0]);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (tx_w[0] !== 1'b1 || cnt_w[0] !== 5'd0 || in_ready[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got tx=%b count=%0d ready=%b busy=%b expected 1 0 1 0",
                     tx_w[0], cnt_w[0], in_ready[0], busy_w[0]);
        end
        @(negedge clk);
        rst   = 1'b1;
        stray = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) stray = 1'b1;
        end
        n_checks++;
        if (stray) begin
            n_fail++; $display("FAIL mid_after_release: got activity=1 expected idle line");
        end
    endtask

`ifdef UART_TX_CTS_EN
    task automatic test_cts();
        logic moved;
        cts_n = 1'b1;
        repeat (3) @(negedge clk);
        send(0, 8'h3C);
        send(0, 8'h5A);
        moved = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1) moved = 1'b1;
        end
        n_checks++;
        if (moved || busy_w[0] !== 1'b1 || cnt_w[0] !== 5'd2) begin
            n_fail++;
            $display("FAIL cts_hold: got moved=%b busy=%b count=%0d expected 0 1 2", moved, busy_w[0], cnt_w[0]);
        end
        cts_n = 1'b0;
        @(negedge clk);
        wait_tx_low(0, 3, "cts_release_start");
        cts_n = 1'b1;
        check_frame(0, 8'h3C, "cts_frame");
        moved = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (tx_w[0] !== 1'b1) moved = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (moved || cnt_w[0] !== 5'd1 || busy_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL cts_next_held: got moved=%b count=%0d busy=%b expected 0 1 1", moved, cnt_w[0], busy_w[0]);
        end
        cts_n = 1'b0;
        wait_tx_low(0, 10, "cts_second_start");
        check_frame(0, 8'h5A, "cts_second_frame");
    endtask
`endif

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_stop_bits();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_TX_CTS_EN
        test_cts();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
